// File: rtl/muldiv_unit_pkg.sv
// Shared ALU control op codes and op-class helpers for the mul/div unit.
// Builds with or without MULDIV_FAST_MUL_EN (single-cycle multiply).
package muldiv_unit_pkg;

    localparam logic [4:0] SIG_ALU_ADD   = 5'b00000;
    localparam logic [4:0] SIG_ALU_SUB   = 5'b00001;
    localparam logic [4:0] SIG_ALU_AND   = 5'b00010;
    localparam logic [4:0] SIG_ALU_OR    = 5'b00011;
    localparam logic [4:0] SIG_ALU_XOR   = 5'b00100;
    localparam logic [4:0] SIG_ALU_SLT   = 5'b00101;
    localparam logic [4:0] SIG_ALU_MULT  = 5'b10000;
    localparam logic [4:0] SIG_ALU_MULTU = 5'b10001;
    localparam logic [4:0] SIG_ALU_DIV   = 5'b10010;
    localparam logic [4:0] SIG_ALU_DIVU  = 5'b10011;

    function automatic logic is_muldiv_op(input logic [4:0] op);
        return (op == SIG_ALU_MULT) || (op == SIG_ALU_MULTU) ||
               (op == SIG_ALU_DIV)  || (op == SIG_ALU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == SIG_ALU_DIV) || (op == SIG_ALU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == SIG_ALU_MULT) || (op == SIG_ALU_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_radix2.sv
// One restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and shift the quotient bit in.
module div_radix2 #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    logic            fits;

    // quo holds the not-yet-consumed dividend bits at its top end
    assign shifted  = {rem, quo[DATA_W-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign fits     = ~diff[DATA_W];
    assign rem_next = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign quo_next = {quo[DATA_W-2:0], fits};

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with stall and flush support.
// MULDIV_FAST_MUL_EN selects a single-cycle multiply; default is shift-add.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        alucontrol,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs;
    logic [DATA_W-1:0] a_raw;
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;

    logic              accept;
    logic              op_div;
    logic              op_sgn;
    logic              last;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;

    logic [DATA_W-1:0]   div_rem;
    logic [DATA_W-1:0]   div_quo;
    logic [DATA_W-1:0]   q_fin;
    logic [DATA_W-1:0]   r_fin;
    logic [2*DATA_W-1:0] prod_raw;
    logic [2*DATA_W-1:0] prod_fin;

    assign op_div = is_div_op(alucontrol);
    assign op_sgn = is_signed_op(alucontrol);
    assign accept = (state == IDLE) & start & ~flush & ~rst &
                    is_muldiv_op(alucontrol);
    assign busy   = ~rst & ((state == MUL) | (state == DIV) | accept);
    assign done   = ~rst & (state == DONE);
    assign last   = (cnt == CNT_W'(DATA_W - 1));

    // Iterate on magnitudes; signs are reapplied when the result is written
    assign mag_a = (op_sgn & a[DATA_W-1]) ? -a : a;
    assign mag_b = (op_sgn & b[DATA_W-1]) ? -b : b;

    div_radix2 #(
        .DATA_W (DATA_W)
    ) u_div (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs),
        .rem_next (div_rem),
        .quo_next (div_quo)
    );

    always_comb begin
        q_fin = neg_q ? -div_quo : div_quo;
        r_fin = neg_r ? -div_rem : div_rem;
        if (div_zero) begin
            q_fin = '1;
            r_fin = a_raw;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    assign prod_raw = {{DATA_W{1'b0}}, dvs} * {{DATA_W{1'b0}}, quo_q};
`else
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W-1:0] mul_hi;
    logic [DATA_W-1:0] mul_lo;

    // rem_q accumulates the high half, quo_q shifts multiplier out / product in
    assign mul_sum  = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs} : '0);
    assign mul_hi   = mul_sum[DATA_W:1];
    assign mul_lo   = {mul_sum[0], quo_q[DATA_W-1:1]};
    assign prod_raw = {mul_hi, mul_lo};
`endif

    assign prod_fin = neg_q ? -prod_raw : prod_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = op_div ? DIV : MUL;
                end
            end
            MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                state_next = DONE;
`else
                if (last) begin
                    state_next = DONE;
                end
`endif
            end
            DIV: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs      <= '0;
            a_raw    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_o     <= '0;
            lo_o     <= '0;
        end else if (flush) begin
            cnt   <= '0;
            rem_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        rem_q    <= '0;
                        quo_q    <= op_div ? mag_a : mag_b;
                        dvs      <= op_div ? mag_b : mag_a;
                        a_raw    <= a;
                        neg_q    <= op_sgn & (a[DATA_W-1] ^ b[DATA_W-1]);
                        neg_r    <= op_sgn & a[DATA_W-1];
                        div_zero <= op_div & (b == '0);
                    end
                end
                MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                    {hi_o, lo_o} <= prod_fin;
`else
                    rem_q <= mul_hi;
                    quo_q <= mul_lo;
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        {hi_o, lo_o} <= prod_fin;
                    end
`endif
                end
                DIV: begin
                    rem_q <= div_rem;
                    quo_q <= div_quo;
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        hi_o <= r_fin;
                        lo_o <= q_fin;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed mul/div operations
// against an arithmetic reference model, plus flush, reset and illegal-op cases.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           at;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [4:0]   alucontrol;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    exp_t         sb[$];
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;
    int           done_cnt = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    muldiv_unit #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [4:0] op,
                                  input logic [W-1:0] x,
                                  input logic [W-1:0] y,
                                  output logic [W-1:0] hi,
                                  output logic [W-1:0] lo);
        longint       sp;
        logic [63:0]  up;
        int           sx;
        int           sy;
        sx = x;
        sy = y;
        hi = '0;
        lo = '0;
        if (op == SIG_ALU_MULT) begin
            sp = longint'(sx) * longint'(sy);
            {hi, lo} = sp;
        end else if (op == SIG_ALU_MULTU) begin
            up = {32'b0, x} * {32'b0, y};
            {hi, lo} = up;
        end else if (y == 0) begin
            lo = '1;
            hi = x;
        end else if (op == SIG_ALU_DIV) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                lo = x;
                hi = '0;
            end else begin
                lo = sx / sy;
                hi = sx % sy;
            end
        end else begin
            lo = x / y;
            hi = x % y;
        end
    endfunction

    function automatic int lat(input logic [4:0] op);
        if (op == SIG_ALU_DIV || op == SIG_ALU_DIVU) return W + 1;
`ifdef MULDIV_FAST_MUL_EN
        return 2;
`else
        return W + 1;
`endif
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = 32'h8000_0000;
            3: v = 32'd1;
            4: v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Scoreboard monitor: every done strobe consumes one expected result
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("hi", hi_o, e.hi);
                chk("lo", lo_o, e.lo);
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    task automatic do_op(input logic [4:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        exp_t e;
        int   n;
        logic held;
        @(negedge clk);
        start = 1'b1;
        alucontrol = op;
        a = x;
        b = y;
        model(op, x, y, e.hi, e.lo);
        e.at = cyc + lat(op);
        sb.push_back(e);
        #1;
        chk("busy_accept", busy, 1);
        n = 0;
        held = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (!done && !busy) held = 1'b0;
        end while (!done && n < 100);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done after %0d cycles expected done", n);
            sb.delete();
        end
        chk("busy_held", held, 1);
        #1;
        chk("busy_in_done", busy, 0);
        start = 1'b0;
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    initial begin
        int dc;
        logic [4:0] ops[4];
        ops[0] = SIG_ALU_MULT;
        ops[1] = SIG_ALU_MULTU;
        ops[2] = SIG_ALU_DIV;
        ops[3] = SIG_ALU_DIVU;

        rst = 1'b1;
        start = 1'b1;
        alucontrol = SIG_ALU_MULT;
        a = 32'd3;
        b = 32'd4;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        start = 1'b0;

        do_op(SIG_ALU_DIVU, 32'd100, 32'd7);
        do_op(SIG_ALU_DIV, 32'hFFFF_FFF9, 32'd2);
        do_op(SIG_ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(SIG_ALU_DIVU, 32'h1234, 32'd0);
        do_op(SIG_ALU_DIV, 32'hFFFF_FF00, 32'd0);
        do_op(SIG_ALU_MULT, 32'hFFFF_FFFD, 32'd5);
        do_op(SIG_ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(SIG_ALU_DIV, 32'd7, 32'hFFFF_FFFE);

        // Flush mid-divide: no result, outputs keep prior values
        @(negedge clk);
        start = 1'b1;
        alucontrol = SIG_ALU_DIV;
        a = 32'd12345;
        b = 32'd11;
        dc = done_cnt;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        chk("flush_busy", busy, 0);
        repeat (40) @(negedge clk);
        chk("flush_nodone", done_cnt, dc);
        chk("flush_hi", hi_o, last_hi);
        chk("flush_lo", lo_o, last_lo);
        do_op(SIG_ALU_DIVU, 32'd1000, 32'd9);

        // Illegal op and flush-with-accept are both ignored
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1;
        alucontrol = SIG_ALU_ADD;
        #1;
        chk("illegal_busy", busy, 0);
        repeat (5) @(negedge clk);
        alucontrol = SIG_ALU_MULT;
        flush = 1'b1;
        #1;
        chk("flush_accept_busy", busy, 0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("ignored_nodone", done_cnt, dc);

        for (int i = 0; i < 40; i++) begin
            do_op(ops[$urandom_range(0, 3)], rnd_operand(), rnd_operand());
        end

        // Reset mid-divide clears the result registers
        @(negedge clk);
        start = 1'b1;
        alucontrol = SIG_ALU_DIVU;
        a = 32'd999;
        b = 32'd3;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_mid_hi", hi_o, 0);
        chk("rst_mid_lo", lo_o, 0);
        chk("rst_mid_busy2", busy, 0);
        do_op(SIG_ALU_MULT, 32'h8000_0000, 32'h8000_0000);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: DATA_W, default 32, operand and result width (even, >=8).
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  level request; operation held stable by E stage until done.
REQ-005 alucontrol  in  5  op select, SIG_ALU_MULT/MULTU/DIV/DIVU codes from shared ALU control defines.
REQ-006 a  in  DATA_W  rs operand (dividend / multiplicand).
REQ-007 b  in  DATA_W  rt operand (divisor / multiplier).
REQ-008 flush  in  1  exception/flush abort.
REQ-009 busy  out  1  stall request to hazard unit.
REQ-010 done  out  1  one-cycle result-valid strobe.
REQ-011 hi_o  out  DATA_W  product high half / remainder.
REQ-012 lo_o  out  DATA_W  product low half / quotient.

Function
REQ-013 FSM states IDLE, MUL, DIV, DONE; only IDLE accepts a request.
REQ-014 Accept: IDLE & start & ~flush & alucontrol in {MULT,MULTU,DIV,DIVU}; next state MUL or DIV; a, b, signedness latched.
REQ-015 start with any other alucontrol: ignored, busy=0, state stays IDLE.
REQ-016 busy = (state==MUL|DIV) | (IDLE & accept condition); combinational, so stall is raised in the accept cycle.
REQ-017 DIV: radix-2 restoring, exactly DATA_W iteration cycles, then DONE; accept at cycle T -> done=1 at T+DATA_W+1.
REQ-018 Signed ops: sign-magnitude conversion at accept, correction at completion; quotient truncates toward zero, remainder takes dividend sign.
REQ-019 Divide by zero: lo_o = all ones, hi_o = a, signed or unsigned, latency unchanged.
REQ-020 Signed most-negative / -1: lo_o = most-negative, hi_o = 0.
REQ-021 MUL: full 2*DATA_W product, {hi_o,lo_o}; latency per REQ-028/029.
REQ-022 DONE: done=1, busy=0, hi_o/lo_o updated in the same edge entering DONE; DONE -> IDLE unconditionally.
REQ-023 start still high in DONE is not re-accepted; a start in the following IDLE cycle is a new operation.
REQ-024 hi_o/lo_o hold last completed result until next completion; never change mid-operation.
REQ-025 flush in any state: next state IDLE, no done, hi_o/lo_o unchanged, iteration state discarded.
REQ-026 flush and accept in same cycle: flush wins, busy=0, nothing accepted.

Reset
REQ-027 rst: state IDLE, counter 0, hi_o=0, lo_o=0, done=0, busy=0 (forced 0 during rst regardless of start); rst mid-operation aborts as flush and additionally clears hi_o/lo_o.

Configuration
REQ-028 MULDIV_FAST_MUL_EN defined: MUL single cycle, combinational DATA_W x DATA_W multiply; accept at T -> done at T+2.
REQ-029 MULDIV_FAST_MUL_EN undefined: MUL iterative shift-add, DATA_W cycles, sharing the divider's counter; accept at T -> done at T+DATA_W+1; results bit-identical to defined case.

Structure
REQ-030 SIG_ALU_* op codes stay in the shared ALU control define header; no new codes added.
REQ-031 FSM state encodings are local parameters of muldiv_unit, not shared.
REQ-032 One sub-module, div_radix2: one-bit restoring-divide step (partial remainder, quotient shift); muldiv_unit owns FSM, counter, sign handling, registers.

Verification (DATA_W=32)
REQ-033 DIVU a=100, b=7 at T -> busy T..T+32, done at T+33, lo=14, hi=2.
REQ-034 DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-035 DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234, done at T+33.
REQ-036 MULT a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=1; done at T+2 with macro, T+33 without.
REQ-037 DIV started, flush at T+10 -> IDLE at T+11, no done, hi/lo keep prior values; new DIVU at T+12 completes at T+45.
REQ-038 start held with alucontrol=SIG_ALU_ADD -> busy=0, no done; rst asserted mid-DIV -> hi=lo=0, busy=0 next cycle.
